uart_tx_switch_arbiter: RTL and testbench
=========================================

Name: uart_tx_switch_arbiter

Overview:
- Shares the single board TXD pin between the CPU UART and the OCD hardware-loader UART.
- Replaces the direct per-cycle mux with a frame-aware arbiter: a change of the requested owner takes effect only at a character boundary.
- Neither source's frame is truncated, and the host never sees a glitched character.
- Sits at top level between the MCU/loader TX outputs and the TXD pad; the request comes from the loader's debug_uart_tx_sel_ocd1_cpu0.

Parameters:
- BAUD_PERIOD, 108, clk cycles per UART bit (MCU_MAIN_CLK_RATE / 921600).
- FRAME_BITS, 10, bits per character: start + 8 data + stop.
- IDLE_BITS, 2, bit periods of continuous mark a line needs before it is treated as idle.
- CNT_W, 16, counter width; must hold FRAME_BITS*BAUD_PERIOD.

Ports:
- clk  in  1  system clock.
- sync_reset  in  1  synchronous active-high reset.
- sel_req_ocd1_cpu0  in  1  requested owner: 1 = OCD, 0 = CPU.
- tx_cpu  in  1  CPU UART serial out.
- tx_ocd  in  1  OCD UART serial out.
- TXD  out  1  registered pad output.
- sel_active_ocd1_cpu0  out  1  current owner.
- switch_pending  out  1  request differs from the current owner.
- frame_busy  out  1  the current owner is mid-frame or in its guard period.

Behaviour:
- Single clock; reset is synchronous and active-high.
  - Applies on any clk edge with sync_reset=1.
  - Overrides any state, including a switch mid-operation.
- Reset values:
  - TXD=1 (mark).
  - sel_active=0 (CPU).
  - switch_pending=0, frame_busy=0.
  - FSM=IDLE, all counters=0.
- Data path: TXD <= (sel_active ? tx_ocd : tx_cpu), registered, latency 1 cycle.
- Idle-run counters run_cpu and run_ocd, one per source:
  - Reset to 0 whenever the source is low.
  - Increment while it is high.
  - Saturate at IDLE_BITS*BAUD_PERIOD; saturation is flagged as idle_x.
- FSM on the active source line act = selected tx:
  - IDLE:
    - act=0 -> FRAME; load bit_cnt=FRAME_BITS*BAUD_PERIOD-1.
    - Otherwise, if switch_pending and idle_(new source) and idle_(act): toggle sel_active next cycle and stay in IDLE.
  - FRAME: decrement bit_cnt; at 0 -> GUARD.
  - GUARD:
    - Wait for idle_(act).
    - If act falls during GUARD (back-to-back characters), return to FRAME with the counter reloaded.
    - When idle_(act) is set -> IDLE.
- frame_busy = (state != IDLE), combinational from the state register.
- switch_pending = sel_req != sel_active, registered, so it lags sel_req by 1 cycle.
- Simultaneous events:
  - If act falls in the same cycle a switch would be granted, the frame start wins and the switch is deferred.
  - Request toggling back before a grant: pending clears and no switch occurs.
- A newly selected source that is mid-frame is never granted, because idle_(new) is required.
- Counters never wrap; bit_cnt underflow is impossible by construction.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES, default 64*FRAME_BITS*BAUD_PERIOD.
  - Adds a pending-age counter, cleared whenever switch_pending=0.
  - When the counter reaches TIMEOUT_CYCLES, the switch is forced next cycle regardless of state or idle flags.
  - On a forced switch: FSM -> IDLE, output bit timeout_flag pulses high 1 cycle.
- When not defined:
  - No counter and no timeout_flag port.
  - A stuck-low owner holds the pin indefinitely.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (ARB_IDLE, ARB_FRAME, ARB_GUARD).
  - Default BAUD_PERIOD derivation from MCU_MAIN_CLK_RATE.
  - The FRAME_BITS constant.
- One natural sub-module, uart_line_idle_detect:
  - Parameterised saturating run counter.
  - Output idle_x.
  - Instanced twice, once per source.

Test Plan:
- Reset, both lines high, sel_req=0 -> after reset TXD=1, sel_active=0. After IDLE_BITS*BAUD_PERIOD=216 cycles, a request of 1 is granted within 2 cycles.
- CPU sends 0x55 while sel_req rises at bit 3 of the frame:
  - TXD reproduces the full 1080-cycle frame from tx_cpu.
  - sel_active flips only after the guard (216 idle cycles).
  - switch_pending=1 throughout the wait.
- Back-to-back CPU characters (stop bit immediately followed by start) with a pending switch:
  - No switch between characters.
  - Grant occurs only after the final character plus 216 idle cycles.
- OCD line mid-frame (low) when CPU goes idle and sel_req=1:
  - No grant until tx_ocd has been high 216 cycles.
  - TXD stays on tx_cpu meanwhile.
- sel_req pulses 1 for 50 cycles during a CPU frame, then returns to 0 -> switch_pending drops and sel_active remains 0.
- sync_reset asserted mid-frame with a switch pending -> next cycle TXD=1, sel_active=0, frame_busy=0. With UART_TX_ARB_TIMEOUT_EN: tx_cpu held low 70 frames with sel_req=1 -> forced switch at TIMEOUT_CYCLES and timeout_flag pulses once.

Source files
------------

// File: rtl/uart_tx_switch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_switch_arbiter_pkg
//   Shared definitions for the TXD pin arbiter between the CPU UART and the
//   OCD hardware-loader UART.
//   - Arbiter FSM state encoding.
//   - Default bit period, derived from the main clock and the 921600 baud rate.
//   - Character framing constant (start + 8 data + stop).
//   - Idle guard length in bit periods.
// -----------------------------------------------------------------------------
package uart_tx_switch_arbiter_pkg;

   localparam int unsigned MCU_MAIN_CLK_RATE   = 99_532_800;
   localparam int unsigned UART_BAUD_RATE      = 921_600;
   localparam int unsigned DEFAULT_BAUD_PERIOD = MCU_MAIN_CLK_RATE / UART_BAUD_RATE;

   localparam int unsigned UART_FRAME_BITS     = 10;
   localparam int unsigned DEFAULT_IDLE_BITS   = 2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FRAME = 2'd1,
      ARB_GUARD = 2'd2
   } arb_state_t;

   // Clock cycles spanned by a number of bit periods.
   function automatic int unsigned bit_cycles(input int unsigned bits,
                                              input int unsigned period);
      return bits * period;
   endfunction

endpackage

// File: rtl/uart_line_idle_detect.sv
// -----------------------------------------------------------------------------
// uart_line_idle_detect
//   Saturating run-length counter on one UART serial line. The count clears
//   whenever the line is low (space) and increments while it is high (mark),
//   stopping at SAT_COUNT. idle_x is set once the line has been at mark for
//   SAT_COUNT consecutive cycles.
//
// Ports
//   clk        in   system clock
//   sync_reset in   synchronous active-high reset
//   line       in   serial line being watched
//   idle_x     out  line has been continuously high for SAT_COUNT cycles
// -----------------------------------------------------------------------------
module uart_line_idle_detect
   import uart_tx_switch_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned SAT_COUNT = bit_cycles(DEFAULT_IDLE_BITS, DEFAULT_BAUD_PERIOD)
)(
   input  logic clk,
   input  logic sync_reset,
   input  logic line,
   output logic idle_x
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_COUNT);

   logic [CNT_W-1:0] run_cnt;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         run_cnt <= '0;
      end else if (!line) begin
         run_cnt <= '0;
      end else if (run_cnt != SAT) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   assign idle_x = (run_cnt == SAT);

endmodule

// File: rtl/uart_tx_switch_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_switch_arbiter
//   Shares the board TXD pin between the CPU UART and the OCD loader UART.
//   A change of the requested owner only takes effect at a character boundary:
//   the current owner must have finished its frame and shown IDLE_BITS of
//   mark, and the incoming source must also be idle, so neither side's frame
//   is cut and the host never sees a glitched character.
//
//   Optional build macro: UART_TX_ARB_TIMEOUT_EN
//     Adds TIMEOUT_CYCLES and a timeout_flag output. A switch left pending for
//     TIMEOUT_CYCLES is forced regardless of line state, so a stuck-low owner
//     cannot hold the pin forever. Without the macro no such escape exists.
//
// Ports
//   clk                  in   system clock
//   sync_reset           in   synchronous active-high reset
//   sel_req_ocd1_cpu0    in   requested owner: 1 = OCD, 0 = CPU
//   tx_cpu               in   CPU UART serial out
//   tx_ocd               in   OCD UART serial out
//   TXD                  out  registered pad output (1 cycle latency)
//   sel_active_ocd1_cpu0 out  current owner
//   switch_pending       out  request differs from current owner (registered)
//   frame_busy           out  current owner is mid-frame or in its guard period
//   timeout_flag         out  (macro only) one-cycle pulse on a forced switch
// -----------------------------------------------------------------------------
module uart_tx_switch_arbiter
   import uart_tx_switch_arbiter_pkg::*;
#(
   parameter int unsigned BAUD_PERIOD    = DEFAULT_BAUD_PERIOD,
   parameter int unsigned FRAME_BITS     = UART_FRAME_BITS,
   parameter int unsigned IDLE_BITS      = DEFAULT_IDLE_BITS,
   parameter int unsigned CNT_W          = 16
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 64 * FRAME_BITS * BAUD_PERIOD
`endif
)(
   input  logic clk,
   input  logic sync_reset,
   input  logic sel_req_ocd1_cpu0,
   input  logic tx_cpu,
   input  logic tx_ocd,
   output logic TXD,
   output logic sel_active_ocd1_cpu0,
   output logic switch_pending,
   output logic frame_busy
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   output logic timeout_flag
`endif
);

   localparam int unsigned     IDLE_CYCLES = bit_cycles(IDLE_BITS, BAUD_PERIOD);
   localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(bit_cycles(FRAME_BITS, BAUD_PERIOD) - 1);

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [CNT_W-1:0] bit_cnt_d;
   logic             sel_active_q;
   logic             sel_active_d;
   logic             pending_q;
   logic             grant;

   logic             idle_cpu;
   logic             idle_ocd;
   logic             act;
   logic             idle_act;
   logic             idle_new;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES);

   logic [AGE_W-1:0] age_q;
   logic             force_sw;
   logic             timeout_q;
`endif

   // -------------------------------------------------------------------------
   // Per-source idle detection
   // -------------------------------------------------------------------------
   uart_line_idle_detect #(
      .CNT_W     (CNT_W),
      .SAT_COUNT (IDLE_CYCLES)
   ) u_idle_cpu (
      .clk        (clk),
      .sync_reset (sync_reset),
      .line       (tx_cpu),
      .idle_x     (idle_cpu)
   );

   uart_line_idle_detect #(
      .CNT_W     (CNT_W),
      .SAT_COUNT (IDLE_CYCLES)
   ) u_idle_ocd (
      .clk        (clk),
      .sync_reset (sync_reset),
      .line       (tx_ocd),
      .idle_x     (idle_ocd)
   );

   assign act      = sel_active_q ? tx_ocd   : tx_cpu;
   assign idle_act = sel_active_q ? idle_ocd : idle_cpu;
   assign idle_new = sel_active_q ? idle_cpu : idle_ocd;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q      <= ARB_IDLE;
         bit_cnt_q    <= '0;
         sel_active_q <= 1'b0;
         pending_q    <= 1'b0;
         TXD          <= 1'b1;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sel_active_q <= sel_active_d;
         // Compared against the post-grant owner so a grant cannot be
         // followed by a second toggle from a stale pending flag.
         pending_q    <= (sel_req_ocd1_cpu0 != sel_active_d);
         TXD          <= act;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         age_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= force_sw;
         if (!pending_q || force_sw) begin
            age_q <= '0;
         end else if (age_q != AGE_LIMIT) begin
            age_q <= age_q + AGE_W'(1);
         end
      end
   end

   assign force_sw = pending_q && (age_q == AGE_LIMIT);
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      grant     = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // A start bit on the owner beats a switch granted in the same cycle.
            if (!act) begin
               state_d   = ARB_FRAME;
               bit_cnt_d = FRAME_LOAD;
            end else if (pending_q && idle_new && idle_act) begin
               grant = 1'b1;
            end
         end

         ARB_FRAME: begin
            if (bit_cnt_q == '0) begin
               state_d = ARB_GUARD;
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
         end

         ARB_GUARD: begin
            // Back-to-back characters: a new start bit before the line has
            // gone idle restarts the frame timer.
            if (!act) begin
               state_d   = ARB_FRAME;
               bit_cnt_d = FRAME_LOAD;
            end else if (idle_act) begin
               state_d = ARB_IDLE;
            end
         end

         default: begin
            state_d   = ARB_IDLE;
            bit_cnt_d = '0;
         end
      endcase

`ifdef UART_TX_ARB_TIMEOUT_EN
      if (force_sw) begin
         state_d   = ARB_IDLE;
         bit_cnt_d = '0;
         grant     = 1'b1;
      end
`endif

      sel_active_d = grant ? ~sel_active_q : sel_active_q;
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      frame_busy           = (state_q != ARB_IDLE);
      sel_active_ocd1_cpu0 = sel_active_q;
      switch_pending       = pending_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_flag         = timeout_q;
`endif
   end

endmodule

// File: tb/tb_uart_tx_switch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_switch_arbiter
//   Directed scenarios for the TXD arbiter. Stimulus pushes expected point
//   values and expected owner changes into queues; a negedge monitor pops and
//   compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_uart_tx_switch_arbiter;

   localparam int BAUD = 108;

   logic clk = 1'b0;
   logic sync_reset;
   logic sel_req;
   logic tx_cpu;
   logic tx_ocd;
   logic TXD;
   logic sel_active;
   logic switch_pending;
   logic frame_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic timeout_flag;
`endif

   uart_tx_switch_arbiter #(
      .BAUD_PERIOD (108),
      .FRAME_BITS  (10),
      .IDLE_BITS   (2),
      .CNT_W       (16)
   ) dut (
      .clk                  (clk),
      .sync_reset           (sync_reset),
      .sel_req_ocd1_cpu0    (sel_req),
      .tx_cpu               (tx_cpu),
      .tx_ocd               (tx_ocd),
      .TXD                  (TXD),
      .sel_active_ocd1_cpu0 (sel_active),
      .switch_pending       (switch_pending),
      .frame_busy           (frame_busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
      ,
      .timeout_flag         (timeout_flag)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // sig: 0 TXD, 1 sel_active, 2 switch_pending, 3 frame_busy
   typedef struct {
      int   cyc;
      int   sig;
      logic val;
   } pt_t;

   typedef struct {
      logic val;
      int   lo;
      int   hi;
   } gr_t;

   pt_t  pt_q[$];
   gr_t  gr_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   mon_en   = 1'b0;
   logic prev_sel = 1'b0;
   logic exp_owner = 1'b0;

   task automatic check(input string nm, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %b, expected %b", nm, cyc, got, exp);
      end
   endtask

   task automatic check_win(input string nm, input int at, input int lo, input int hi);
      n_checks++;
      if (at < lo || at > hi) begin
         n_err++;
         $display("FAIL %s: switched at cyc %0d, expected within [%0d,%0d]", nm, at, lo, hi);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      pt_t p;
      gr_t g;
      while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
         p = pt_q.pop_front();
         case (p.sig)
            0:       check("TXD", TXD, p.val);
            1:       check("sel_active", sel_active, p.val);
            2:       check("switch_pending", switch_pending, p.val);
            default: check("frame_busy", frame_busy, p.val);
         endcase
      end
      if (mon_en && sel_active !== prev_sel) begin
         if (gr_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_switch @cyc %0d: got sel_active=%b, expected no change",
                     cyc, sel_active);
         end else begin
            g = gr_q.pop_front();
            check("switch_value", sel_active, g.val);
            check_win("switch_time", cyc, g.lo, g.hi);
         end
      end
      prev_sel = sel_active;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_pt(input int sig, input logic v);
      pt_t p;
      p.cyc = cyc;
      p.sig = sig;
      p.val = v;
      pt_q.push_back(p);
   endtask

   task automatic expect_grant(input logic v, input int lo, input int hi);
      gr_t g;
      g.val = v;
      g.lo  = lo;
      g.hi  = hi;
      gr_q.push_back(g);
   endtask

   // Request a switch while both lines are idle: granted within 2 cycles.
   task automatic request(input logic v);
      sel_req = v;
      expect_grant(v, cyc + 1, cyc + 3);
      ticks(10);
      exp_owner = v;
      expect_pt(1, v);
      expect_pt(2, 1'b0);
   endtask

   // Send one 8N1 character. Optionally changes sel_req at the start of
   // bit req_bit (held, or pulsed for pulse_len cycles) and optionally
   // applies a one-cycle reset in the middle of bit rst_bit.
   task automatic send_char(input logic [7:0] data, input bit on_ocd,
                            input int req_bit, input logic req_val,
                            input int pulse_len, input int rst_bit);
      logic [9:0] frame;
      int         off_at;
      int         on_at;
      frame  = {1'b1, data, 1'b0};
      off_at = -1;
      on_at  = -1;
      for (int b = 0; b < 10; b++) begin
         if (on_ocd) tx_ocd = frame[b];
         else        tx_cpu = frame[b];
         if (b == req_bit) begin
            sel_req = req_val;
            on_at   = cyc;
            if (pulse_len > 0) off_at = cyc + pulse_len;
         end
         for (int t = 0; t < BAUD; t++) begin
            tick();
            if (cyc == off_at) sel_req = ~req_val;
            if (pulse_len > 0 && cyc == on_at + 21) expect_pt(2, 1'b1);
            if (t == 53) begin
               expect_pt(0, (on_ocd == exp_owner) ? frame[b] : 1'b1);
               expect_pt(3, on_ocd == exp_owner);
               expect_pt(2, sel_req != exp_owner);
               if (b == rst_bit) begin
                  sync_reset = 1'b1;
                  if (exp_owner) expect_grant(1'b0, cyc + 1, cyc + 1);
               end
            end
            if (t == 54 && b == rst_bit) begin
               sync_reset = 1'b0;
               exp_owner  = 1'b0;
               expect_pt(0, 1'b1);
               expect_pt(1, 1'b0);
               expect_pt(2, 1'b0);
               expect_pt(3, 1'b0);
            end
         end
      end
   endtask

   initial begin
      int f;

      // Reset state with both lines low and a request present.
      sync_reset = 1'b1;
      tx_cpu     = 1'b0;
      tx_ocd     = 1'b0;
      sel_req    = 1'b1;
      ticks(3);
      expect_pt(0, 1'b1);
      expect_pt(1, 1'b0);
      expect_pt(2, 1'b0);
      expect_pt(3, 1'b0);
      sync_reset = 1'b0;
      tx_cpu     = 1'b1;
      tx_ocd     = 1'b1;
      sel_req    = 1'b0;
      mon_en     = 1'b1;

      // Both lines idle for 216+ cycles, then request OCD.
      ticks(220);
      request(1'b1);

      // Back to CPU, then a CPU 0x55 frame with the request rising at bit 3.
      request(1'b0);
      f = cyc;
      expect_grant(1'b1, f + 1186, f + 1194);
      send_char(8'h55, 1'b0, 3, 1'b1, 0, -1);
      expect_pt(3, 1'b1);
      expect_pt(2, 1'b1);
      ticks(150);
      exp_owner = 1'b1;
      expect_pt(1, 1'b1);
      expect_pt(2, 1'b0);
      expect_pt(3, 1'b0);

      // Back-to-back CPU characters with a pending switch.
      request(1'b0);
      f = cyc;
      expect_grant(1'b1, f + 3346, f + 3354);
      send_char(8'h55, 1'b0, 0, 1'b1, 0, -1);
      send_char(8'h2A, 1'b0, -1, 1'b1, 0, -1);
      send_char(8'h25, 1'b0, -1, 1'b1, 0, -1);
      ticks(150);
      exp_owner = 1'b1;
      expect_pt(1, 1'b1);

      // OCD mid-frame while the CPU owner is idle and OCD is requested.
      request(1'b0);
      f = cyc;
      expect_grant(1'b1, f + 1185, f + 1193);
      send_char(8'h55, 1'b1, 0, 1'b1, 0, -1);
      ticks(150);
      exp_owner = 1'b1;
      expect_pt(1, 1'b1);

      // Request pulse of 50 cycles during a CPU frame: no switch.
      request(1'b0);
      send_char(8'h55, 1'b0, 2, 1'b1, 50, -1);
      ticks(250);
      expect_pt(1, 1'b0);
      expect_pt(2, 1'b0);

      // Reset mid-frame with a switch pending.
      request(1'b1);
      send_char(8'h00, 1'b1, 0, 1'b0, 0, 4);
      ticks(300);
      expect_pt(1, 1'b0);
      expect_pt(2, 1'b0);
      ticks(3);

      n_checks++;
      if (pt_q.size() != 0) begin
         n_err++;
         $display("FAIL point_queue: got %0d unchecked entries, expected 0", pt_q.size());
      end
      n_checks++;
      if (gr_q.size() != 0) begin
         n_err++;
         $display("FAIL switch_queue: got %0d missing switches, expected 0", gr_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
